// File: rtl/tcm_pkg.sv
// tcm_pkg: shared widths, legal parameter ranges and the data response record for the TCM.
package tcm_pkg;
    localparam int TAG_W     = 11;
    localparam int D_LAT_MIN = 1;
    localparam int D_LAT_MAX = 4;
    localparam int D_OUT_MIN = 1;
    localparam int D_OUT_MAX = 4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             error;
    } d_resp_t;

    // Written as an offset compare so BASE+SIZE may wrap past 2^32 safely.
    function automatic logic in_range(input logic [31:0] a, input logic [31:0] base, input logic [31:0] size);
        return (a >= base) && ((a - base) < size);
    endfunction
endpackage

// File: rtl/tcm_d_resp_pipe.sv
// tcm_d_resp_pipe: fixed-latency in-order data response shift pipeline with in-flight request counter.
module tcm_d_resp_pipe
    import tcm_pkg::*;
#(
    parameter int LATENCY     = 1,
    parameter int OUTSTANDING = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    req_i,
    input  d_resp_t req_resp_i,
    output logic    accept_o,
    output d_resp_t resp_o
);
    d_resp_t    stage [LATENCY];
    logic [2:0] cnt;

    assign resp_o   = stage[LATENCY-1];
    assign accept_o = rst_ni && req_i &&
                      (cnt < 3'(OUTSTANDING) || (cnt == 3'(OUTSTANDING) && resp_o.valid));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
            cnt <= '0;
        end else begin
            stage[0] <= accept_o ? req_resp_i : '0;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
            cnt <= cnt + 3'(accept_o) - 3'(resp_o.valid);
        end
    end
endmodule

// File: rtl/tcm_mem_param.sv
// tcm_mem_param: tightly coupled memory with fetch and data ports plus backdoor load.
// Define TCM_SINGLE_PORT_EN to model a single-ported RAM where data requests win over fetches.
module tcm_mem_param
    import tcm_pkg::*;
#(
    parameter int          SIZE_BYTES    = 131072,
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          FETCH_W       = 64,
    parameter int          D_LATENCY     = 1,
    parameter int          D_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mem_i_rd_i,
    input  logic               mem_i_flush_i,
    input  logic               mem_i_invalidate_i,
    input  logic [31:0]        mem_i_pc_i,
    output logic               mem_i_accept_o,
    output logic               mem_i_valid_o,
    output logic               mem_i_error_o,
    output logic [FETCH_W-1:0] mem_i_inst_o,
    input  logic [31:0]        mem_d_addr_i,
    input  logic [31:0]        mem_d_data_wr_i,
    input  logic               mem_d_rd_i,
    input  logic [3:0]         mem_d_wr_i,
    input  logic [TAG_W-1:0]   mem_d_req_tag_i,
    input  logic               mem_d_cacheable_i,
    input  logic               mem_d_invalidate_i,
    input  logic               mem_d_writeback_i,
    input  logic               mem_d_flush_i,
    output logic               mem_d_accept_o,
    output logic               mem_d_ack_o,
    output logic               mem_d_error_o,
    output logic [31:0]        mem_d_data_rd_o,
    output logic [TAG_W-1:0]   mem_d_resp_tag_o,
    input  logic               bd_wr_i,
    input  logic [31:0]        bd_addr_i,
    input  logic [31:0]        bd_data_i
);
    localparam int WORDS = SIZE_BYTES / 4;
    localparam int AW    = $clog2(WORDS);

    if (D_LATENCY < D_LAT_MIN || D_LATENCY > D_LAT_MAX || D_OUTSTANDING < D_OUT_MIN ||
        D_OUTSTANDING > D_OUT_MAX || (FETCH_W != 32 && FETCH_W != 64) || SIZE_BYTES < 4096 ||
        (SIZE_BYTES & (SIZE_BYTES - 1)) != 0) begin : g_bad_param
        $error("tcm_mem_param: illegal parameter combination");
    end

    logic [31:0]        ram [WORDS];
    logic [31:0]        i_off, d_off;
    logic [AW-1:0]      i_idx, d_idx;
    logic [FETCH_W-1:0] i_data;
    logic               i_in, i_fire, d_in, d_maint, d_req, d_we;
    d_resp_t            d_req_resp, d_resp;
    logic               unused_ok;

    assign i_off = mem_i_pc_i - BASE_ADDR;
    assign d_off = mem_d_addr_i - BASE_ADDR;
    assign d_idx = d_off[AW+1:2];
    assign i_in  = in_range(mem_i_pc_i & ~32'(FETCH_W/8 - 1), BASE_ADDR, 32'(SIZE_BYTES));
    assign d_in  = in_range(mem_d_addr_i, BASE_ADDR, 32'(SIZE_BYTES));

    if (FETCH_W == 64) begin : g_f64
        assign i_idx  = {i_off[AW+1:3], 1'b0};
        assign i_data = {ram[{i_idx[AW-1:1], 1'b1}], ram[i_idx]};
    end else begin : g_f32
        assign i_idx  = i_off[AW+1:2];
        assign i_data = ram[i_idx];
    end

    assign d_maint    = mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i;
    assign d_req      = (mem_d_rd_i || (|mem_d_wr_i) || d_maint) && !bd_wr_i;
    assign d_we       = mem_d_accept_o && !d_maint && d_in;
    assign d_req_resp = '{valid: 1'b1, tag: mem_d_req_tag_i,
                          data: (mem_d_rd_i && !d_maint && d_in) ? ram[d_idx] : 32'h0,
                          error: !d_maint && !d_in};

`ifdef TCM_SINGLE_PORT_EN
    assign mem_i_accept_o = rst_ni && mem_i_rd_i && !bd_wr_i && !mem_d_accept_o;
`else
    assign mem_i_accept_o = rst_ni && mem_i_rd_i && !bd_wr_i;
`endif
    assign i_fire = mem_i_accept_o && !(mem_i_flush_i || mem_i_invalidate_i);

    tcm_d_resp_pipe #(.LATENCY(D_LATENCY), .OUTSTANDING(D_OUTSTANDING)) u_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (d_req),
        .req_resp_i(d_req_resp),
        .accept_o  (mem_d_accept_o),
        .resp_o    (d_resp)
    );

    assign mem_d_ack_o      = d_resp.valid;
    assign mem_d_resp_tag_o = d_resp.tag;
    assign mem_d_data_rd_o  = d_resp.data;
    assign mem_d_error_o    = d_resp.error;

    // No reset on the array: contents must survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (bd_wr_i) ram[bd_addr_i[AW-1:0]] <= bd_data_i;
        else if (d_we)
            for (int b = 0; b < 4; b++)
                if (mem_d_wr_i[b]) ram[d_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_i_valid_o <= 1'b0;
            mem_i_error_o <= 1'b0;
            mem_i_inst_o  <= '0;
        end else begin
            mem_i_valid_o <= i_fire;
            mem_i_error_o <= i_fire && !i_in;
            mem_i_inst_o  <= (i_fire && i_in) ? i_data : '0;
        end
    end

    assign unused_ok = ^{mem_d_cacheable_i, i_off, d_off, bd_addr_i};
endmodule
